laststage: RTL and testbench
============================

# laststage

Final radix-2 butterfly of the 1-sample-per-clock decimation-in-frequency FFT pipeline. It sits directly downstream of the 4-point (`qtrstage`) stage and consumes its sample stream and `o_sync`. It combines adjacent sample pairs x[2k], x[2k+1] into y[2k] = x[2k] + x[2k+1] and y[2k+1] = x[2k] − x[2k+1], using adds and subtracts only. The twiddle factor is always 1, so there is no multiplier and no INVERSE parameter. Output order is bit-reversed, exactly as received; reordering happens downstream.

## Interface
- `IWIDTH`, 16: width of each real/imag input component, signed.
- `OWIDTH`, `IWIDTH+1`: width of each real/imag output component, signed.
- `SHIFT`, 0: number of MSBs discarded before rounding. Passed to `convround`.

- `i_clk`  in  1  clock; the only clock.
- `i_reset`  in  1  reset, asynchronous, active-high.
- `i_clk_enable`  in  1  sample strobe; all state advances only when high.
- `i_sync`  in  1  marks x[0] of a frame; qualified by `i_clk_enable`.
- `i_data`  in  2*IWIDTH  {real, imag}, two's complement.
- `o_data`  out  2*OWIDTH  {real, imag}, two's complement.
- `o_sync`  out  1  high alongside y[0] of each frame.

## Operation
- Pair phase bit `phase`:
  - 0 means the current sample is the first of a pair; 1 means second.
  - Toggles on every enabled sample once locked.
- Lock flag `wait_for_sync`:
  - Set by reset.
  - Cleared by the first enabled `i_sync`.
  - While set, samples are ignored and `phase` stays 0.
- First sample of a pair (`phase` = 0): store it in `prev`.
- Second sample (`phase` = 1), registered:
  - `sum_r` = prev_r + i_r, `sum_i` = prev_i + i_i.
  - `diff_r` = prev_r − i_r, `diff_i` = prev_i − i_i.
  - All four are IWIDTH+1 bits, sign-extended, so they cannot overflow.
- Rounding: four `convround` instances (IWIDTH+1 → OWIDTH, SHIFT), each with one registered cycle.
  - SHIFT MSBs are discarded.
  - Excess LSBs are dropped with round-half-to-even.
  - With defaults the result is exact.
- Output:
  - Emit rounded sum first, then rounded diff on the next enabled cycle.
  - Diff is held in a one-entry buffer until then.
- Resync rule: an enabled `i_sync` while `phase` = 1 restarts pairing.
  - That sample becomes x[0] of a new pair.
  - The incomplete previous pair is discarded and produces no output.
  - Pairs already in the pipeline complete normally.
- Valid tracking: a 3-bit valid shift register, advanced on enable, tracks pair results and the sync tag.
  - `o_data` only changes when a valid sum or diff reaches the output.
  - It stays 0 until the first result after reset.

## Timing
- Reset (async): `o_data` = 0, `o_sync` = 0, `wait_for_sync` = 1, `phase` = 0, valid bits = 0.
  - `prev`, the sum/diff registers and the convround registers are not reset; valid gating hides them.
- All timing is counted in enabled clocks (e0 = the cycle x[2k] is accepted). Disabled cycles freeze every register.
  - e1: x[2k+1] accepted; sum/diff registered.
  - e2: convround output registered.
  - e3: `o_data` = y[2k]; `o_sync` = 1 if x[2k] carried `i_sync`.
  - e4: `o_data` = y[2k+1]; `o_sync` = 0.
- Latency is 3 enabled clocks, input to output. Throughput is one sample per enabled clock, continuous.
- `o_sync` is a single-enabled-cycle pulse. It is held while `i_clk_enable` is low, like `o_data`.
- Reset mid-frame: outputs are 0 immediately. The block relocks only on the next `i_sync`.

## Structure
- No shared package entries are needed. Widths derive from parameters; the pair/valid logic stays local.
- Reuse the existing `convround` sub-module (4 instances). No new sub-module.

## Test plan
- Basic pair, IWIDTH=16, OWIDTH=17, continuous enable. Input x0 = (100, −50) with `i_sync`, then x1 = (30, 20).
  - Required: y0 = (130, −30) with `o_sync`, 3 enables after x0.
  - Required: y1 = (70, −70) on the next enable, with `o_sync` = 0.
- Extremes:
  - x0 = (32767, −32768), x1 = (−32768, 32767) → y0 = (−1, −1), y1 = (65535, −65535).
  - No wrap is allowed.
- Enable gaps: same stimulus as the basic pair, with `i_clk_enable` toggling 1-0-0-1.
  - Required: identical output sequence.
  - Required: `o_data` and `o_sync` held through disabled cycles.
- Rounding, OWIDTH=16, SHIFT=0:
  - Sums 3, 5, −3 → outputs 2, 2, −2 (round half to even).
- Resync and lock: no `i_sync` before the first frame, then `i_sync` on the second sample of a pair.
  - Required: no output before lock.
  - Required: the new pair's y0 carries `o_sync`; the broken pair produces nothing.
- Reset mid-frame: assert `i_reset` asynchronously between clock edges during streaming.
  - Required: `o_data` = 0 and `o_sync` = 0 immediately.
  - Required: after release, outputs stay 0 until 3 enables after the next `i_sync`.

Source files
------------

// File: rtl/laststage_pkg.sv
// Shared constants for the final radix-2 FFT butterfly stage.
package laststage_pkg;
  localparam int VLD_STAGES = 3;
endpackage

// File: rtl/convround.sv
// Convergent rounding: drop SHIFT MSBs, then round excess LSBs half-to-even.
module convround #(
  parameter int IWID  = 17,
  parameter int OWID  = 17,
  parameter int SHIFT = 0
) (
  input  logic                   i_clk,
  input  logic                   i_ce,
  input  logic signed [IWID-1:0] i_val,
  output logic signed [OWID-1:0] o_val
);
  localparam int TW = IWID - SHIFT;

  logic [TW-1:0] t;
  assign t = i_val[TW-1:0];

  generate
    if (TW <= OWID) begin : g_ext
      always_ff @(posedge i_clk)
        if (i_ce) o_val <= OWID'(signed'(t));
    end else begin : g_rnd
      localparam int DROP = TW - OWID;
      logic [OWID-1:0] keep;
      logic            rnd_up;
      assign keep = t[TW-1:DROP];
      // Exact half rounds toward the even neighbour.
      if (DROP == 1) begin : g_d1
        assign rnd_up = t[0] & keep[0];
      end else begin : g_dn
        assign rnd_up = t[DROP-1] & (keep[0] | (|t[DROP-2:0]));
      end
      always_ff @(posedge i_clk)
        if (i_ce) o_val <= keep + OWID'(rnd_up);
    end
  endgenerate
endmodule

// File: rtl/laststage.sv
// Final DIF FFT butterfly: y[2k]=x[2k]+x[2k+1], y[2k+1]=x[2k]-x[2k+1], bit-reversed order.
module laststage
  import laststage_pkg::*;
#(
  parameter int IWIDTH = 16,
  parameter int OWIDTH = IWIDTH + 1,
  parameter int SHIFT  = 0
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic                  i_clk_enable,
  input  logic                  i_sync,
  input  logic [2*IWIDTH-1:0]   i_data,
  output logic [2*OWIDTH-1:0]   o_data,
  output logic                  o_sync
);
  logic signed [IWIDTH-1:0] in_r, in_i, prev_r, prev_i;
  logic signed [IWIDTH:0]   sum_r, sum_i, diff_r, diff_i;
  logic signed [OWIDTH-1:0] rs_r, rs_i, rd_r, rd_i;
  logic [2*OWIDTH-1:0]      dbuf;
  logic                     wait_for_sync, phase, sync_tag;
  logic [VLD_STAGES-1:0]    vld_pipe;
  logic [1:0]               sync_pipe;
  logic                     accept, start_pair, pair_done;

  assign in_r = i_data[2*IWIDTH-1:IWIDTH];
  assign in_i = i_data[IWIDTH-1:0];

  // A sync always opens a fresh pair, abandoning any half-built one.
  assign accept     = i_clk_enable && (!wait_for_sync || i_sync);
  assign start_pair = accept && (i_sync || !phase);
  assign pair_done  = accept && phase && !i_sync;

  always_ff @(posedge i_clk or posedge i_reset)
    if (i_reset) begin
      wait_for_sync <= 1'b1;
      phase         <= 1'b0;
      sync_tag      <= 1'b0;
      vld_pipe      <= '0;
      sync_pipe     <= '0;
    end else if (i_clk_enable) begin
      vld_pipe  <= {vld_pipe[VLD_STAGES-2:0], pair_done};
      sync_pipe <= {sync_pipe[0], pair_done & sync_tag};
      if (start_pair) begin
        wait_for_sync <= 1'b0;
        phase         <= 1'b1;
        sync_tag      <= i_sync;
      end else if (pair_done) begin
        phase <= 1'b0;
      end
    end

  always_ff @(posedge i_clk) begin
    if (start_pair) begin
      prev_r <= in_r;
      prev_i <= in_i;
    end
    if (pair_done) begin
      sum_r  <= {prev_r[IWIDTH-1], prev_r} + {in_r[IWIDTH-1], in_r};
      sum_i  <= {prev_i[IWIDTH-1], prev_i} + {in_i[IWIDTH-1], in_i};
      diff_r <= {prev_r[IWIDTH-1], prev_r} - {in_r[IWIDTH-1], in_r};
      diff_i <= {prev_i[IWIDTH-1], prev_i} - {in_i[IWIDTH-1], in_i};
    end
    if (i_clk_enable && vld_pipe[1])
      dbuf <= {rd_r, rd_i};
  end

  convround #(.IWID(IWIDTH+1), .OWID(OWIDTH), .SHIFT(SHIFT)) u_rnd_sr (
    .i_clk(i_clk), .i_ce(i_clk_enable), .i_val(sum_r),  .o_val(rs_r));
  convround #(.IWID(IWIDTH+1), .OWID(OWIDTH), .SHIFT(SHIFT)) u_rnd_si (
    .i_clk(i_clk), .i_ce(i_clk_enable), .i_val(sum_i),  .o_val(rs_i));
  convround #(.IWID(IWIDTH+1), .OWID(OWIDTH), .SHIFT(SHIFT)) u_rnd_dr (
    .i_clk(i_clk), .i_ce(i_clk_enable), .i_val(diff_r), .o_val(rd_r));
  convround #(.IWID(IWIDTH+1), .OWID(OWIDTH), .SHIFT(SHIFT)) u_rnd_di (
    .i_clk(i_clk), .i_ce(i_clk_enable), .i_val(diff_i), .o_val(rd_i));

  // Sum goes out first; the buffered diff follows one enable later.
  always_ff @(posedge i_clk or posedge i_reset)
    if (i_reset) begin
      o_data <= '0;
      o_sync <= 1'b0;
    end else if (i_clk_enable) begin
      o_sync <= vld_pipe[1] & sync_pipe[1];
      if (vld_pipe[1])
        o_data <= {rs_r, rs_i};
      else if (vld_pipe[2])
        o_data <= dbuf;
    end
endmodule

// File: tb/tb_laststage.sv
// Directed bench for laststage: default widths plus an OWIDTH=16 rounding instance.
module tb_laststage;
  logic        clk = 1'b0;
  logic        rst;
  logic        en, sync;
  logic [31:0] din;
  logic [33:0] dout;
  logic        dsync;
  logic [31:0] rout;
  logic        rsync;
  int          n_cmp = 0;
  int          n_err = 0;

  always #5 clk = ~clk;

  laststage u_dut (
    .i_clk(clk), .i_reset(rst), .i_clk_enable(en), .i_sync(sync),
    .i_data(din), .o_data(dout), .o_sync(dsync));

  laststage #(.IWIDTH(16), .OWIDTH(16), .SHIFT(0)) u_rnd (
    .i_clk(clk), .i_reset(rst), .i_clk_enable(en), .i_sync(sync),
    .i_data(din), .o_data(rout), .o_sync(rsync));

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [33:0] pk17(input int r, input int i);
    logic [16:0] a, b;
    a = r[16:0];
    b = i[16:0];
    return {a, b};
  endfunction

  function automatic logic [31:0] pk16(input int r, input int i);
    logic [15:0] a, b;
    a = r[15:0];
    b = i[15:0];
    return {a, b};
  endfunction

  task automatic tick(input logic e, input logic s, input int r, input int i);
    logic [15:0] a, b;
    a    = r[15:0];
    b    = i[15:0];
    en   = e;
    sync = s;
    din  = {a, b};
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; sync = 1'b0; din = '0;
    #22;
    chk("rst_data", 64'(dout), 64'd0);
    chk("rst_sync", 64'(dsync), 64'd0);
    rst = 1'b0;

    // basic pair
    tick(1, 1, 100, -50);
    tick(1, 0, 30, 20);
    tick(1, 0, 0, 0);
    tick(1, 0, 0, 0);
    chk("basic_y0", 64'(dout), 64'(pk17(130, -30)));
    chk("basic_y0_sync", 64'(dsync), 64'd1);
    tick(1, 0, 0, 0);
    chk("basic_y1", 64'(dout), 64'(pk17(70, -70)));
    chk("basic_y1_sync", 64'(dsync), 64'd0);

    // extremes, no wrap
    tick(1, 1, 32767, -32768);
    tick(1, 0, -32768, 32767);
    tick(1, 0, 0, 0);
    tick(1, 0, 0, 0);
    chk("ext_y0", 64'(dout), 64'(pk17(-1, -1)));
    tick(1, 0, 0, 0);
    chk("ext_y1", 64'(dout), 64'(pk17(65535, -65535)));

    // enable gaps; disabled-cycle inputs must be ignored
    tick(1, 1, 100, -50);
    tick(0, 1, 999, 999);
    tick(0, 1, 999, 999);
    tick(1, 0, 30, 20);
    tick(1, 0, 0, 0);
    tick(0, 1, 999, 999);
    tick(1, 0, 0, 0);
    chk("gap_y0", 64'(dout), 64'(pk17(130, -30)));
    chk("gap_y0_sync", 64'(dsync), 64'd1);
    tick(0, 0, 0, 0);
    chk("gap_hold1", 64'(dout), 64'(pk17(130, -30)));
    chk("gap_hold1_sync", 64'(dsync), 64'd1);
    tick(0, 0, 0, 0);
    chk("gap_hold2", 64'(dout), 64'(pk17(130, -30)));
    chk("gap_hold2_sync", 64'(dsync), 64'd1);
    tick(1, 0, 0, 0);
    chk("gap_y1", 64'(dout), 64'(pk17(70, -70)));
    chk("gap_y1_sync", 64'(dsync), 64'd0);

    // rounding on the OWIDTH=16 instance: sums (3,5) then (-3,0)
    tick(1, 1, 1, 3);
    tick(1, 0, 2, 2);
    tick(1, 0, -1, 0);
    tick(1, 0, -2, 0);
    chk("exact_sum", 64'(dout), 64'(pk17(3, 5)));
    chk("rnd_s0", 64'(rout), 64'(pk16(2, 2)));
    chk("rnd_s0_sync", 64'(rsync), 64'd1);
    tick(1, 0, 0, 0);
    chk("rnd_d0", 64'(rout), 64'(pk16(0, 0)));
    tick(1, 0, 0, 0);
    chk("rnd_s1", 64'(rout), 64'(pk16(-2, 0)));
    chk("rnd_s1_sync", 64'(rsync), 64'd0);
    tick(1, 0, 0, 0);
    chk("rnd_d1", 64'(rout), 64'(pk16(0, 0)));

    // lock and resync
    #2 rst = 1'b1;
    #2 rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick(1, 0, 5, 5);
      chk("nolock", 64'(dout), 64'd0);
    end
    tick(1, 1, 10, 0);
    tick(1, 1, 20, 0);
    tick(1, 0, 7, 0);
    tick(1, 0, 0, 0);
    chk("broken_pair", 64'(dout), 64'd0);
    chk("broken_pair_sync", 64'(dsync), 64'd0);
    tick(1, 0, 0, 0);
    chk("resync_y0", 64'(dout), 64'(pk17(27, 0)));
    chk("resync_y0_sync", 64'(dsync), 64'd1);
    tick(1, 0, 0, 0);
    chk("resync_y1", 64'(dout), 64'(pk17(13, 0)));

    // asynchronous reset mid-stream
    tick(1, 1, 50, 50);
    tick(1, 0, 1, 1);
    tick(1, 0, 0, 0);
    tick(1, 0, 0, 0);
    chk("pre_rst", 64'(dout), 64'(pk17(51, 51)));
    #2 rst = 1'b1;
    #1;
    chk("async_rst_data", 64'(dout), 64'd0);
    chk("async_rst_sync", 64'(dsync), 64'd0);
    #2 rst = 1'b0;
    for (int k = 0; k < 4; k++) begin
      tick(1, 0, 9, 9);
      chk("post_rst_idle", 64'(dout), 64'd0);
    end
    tick(1, 1, 3, 4);
    tick(1, 0, 1, 1);
    tick(1, 0, 0, 0);
    chk("post_rst_e2", 64'(dout), 64'd0);
    tick(1, 0, 0, 0);
    chk("post_rst_y0", 64'(dout), 64'(pk17(4, 5)));
    chk("post_rst_y0_sync", 64'(dsync), 64'd1);
    tick(1, 0, 0, 0);
    chk("post_rst_y1", 64'(dout), 64'(pk17(2, 3)));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
